eflash_out_seq_ctrl: RTL and testbench

//  Sequencer for the eFlash output buffer/encoder path. On start_i it runs
//  NUM_OPS read operations: per op it requests one (rbr) or two (parallel)
//  8-bit eFlash sense results, steers them into buffer slot 1/2 via
//  buf_write_en_1/2, then opens buf_read_en for one valid/ready handshake

---
 rtl/eflash_out_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_eflash_out_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eflash_out_seq_ctrl.sv
// Read-operation sequencer for the eFlash output buffer/encoder path: issues sense
// requests, steers sense data into buffer slots and hands each result downstream.
module eflash_out_seq_ctrl #(
   parameter int OPS_W       = 4,
   parameter int TIMEOUT_W   = 8,
   parameter int TIMEOUT_MAX = 200
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             mode_cfg_i,
   input  logic [OPS_W-1:0] num_ops_i,
   input  logic             eflash_valid_i,
   input  logic             out_ready_i,
   output logic             eflash_req_o,
   output logic             mode_o,
   output logic             buf_write_en_1_o,
   output logic             buf_write_en_2_o,
   output logic             buf_read_en_o,
   output logic             result_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o
);

   typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, READ} state_t;

   state_t               state;
   state_t               state_next;
   logic                 mode_q;
   logic [OPS_W-1:0]     num_ops_q;
   logic [OPS_W-1:0]     op_cnt;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 done_q;
   logic                 timeout_q;
   logic                 done_next;
   logic                 timeout_next;
   logic                 wait_expired;
   logic                 last_op;
   logic                 in_wait;

   assign wait_expired = (wait_cnt == TIMEOUT_W'(TIMEOUT_MAX - 1));
   assign last_op      = (op_cnt == num_ops_q - OPS_W'(1));
   assign in_wait      = (state == WAIT1) || (state == WAIT2);

   assign mode_o    = mode_q;
   assign done_o    = done_q;
   assign timeout_o = timeout_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         num_ops_q <= '0;
         op_cnt    <= '0;
         wait_cnt  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         done_q    <= done_next;
         timeout_q <= timeout_next;

         // A run of zero ops is treated as a single op so last_op can terminate it.
         if (state == IDLE && start_i) begin
            mode_q    <= mode_cfg_i;
            num_ops_q <= (num_ops_i == '0) ? OPS_W'(1) : num_ops_i;
            op_cnt    <= '0;
         end else if (state == READ && out_ready_i && !last_op) begin
            op_cnt <= op_cnt + OPS_W'(1);
         end

         if (state == REQ1 || state == REQ2) begin
            wait_cnt <= '0;
         end else if (in_wait && !eflash_valid_i && !wait_expired) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
         end
      end
   end

   // Sense valid is checked before the timeout so data on the last allowed cycle wins.
   always_comb begin
      state_next       = state;
      done_next        = 1'b0;
      timeout_next     = 1'b0;
      eflash_req_o     = 1'b0;
      buf_write_en_1_o = 1'b0;
      buf_write_en_2_o = 1'b0;
      buf_read_en_o    = 1'b0;
      result_valid_o   = 1'b0;
      busy_o           = (state != IDLE);

      case (state)
         IDLE: begin
            if (start_i) state_next = REQ1;
         end
         REQ1: begin
            eflash_req_o = 1'b1;
            state_next   = WAIT1;
         end
         WAIT1: begin
            buf_write_en_1_o = eflash_valid_i;
            if (eflash_valid_i) begin
               state_next = mode_q ? REQ2 : READ;
            end else if (wait_expired) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         REQ2: begin
            eflash_req_o = 1'b1;
            state_next   = WAIT2;
         end
         WAIT2: begin
            buf_write_en_2_o = eflash_valid_i;
            if (eflash_valid_i) begin
               state_next = READ;
            end else if (wait_expired) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
            end
         end
         READ: begin
            buf_read_en_o  = 1'b1;
            result_valid_o = 1'b1;
            if (out_ready_i) begin
               if (last_op) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  state_next = REQ1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_eflash_out_seq_ctrl.sv
// Directed bench for eflash_out_seq_ctrl: rbr/parallel runs, READ backpressure,
// sense timeout boundary, start while busy, start in done cycle, reset mid-run.
module tb_eflash_out_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       mode_cfg;
   logic [3:0] num_ops;
   logic       eflash_valid;
   logic       out_ready;
   logic       eflash_req;
   logic       mode;
   logic       buf_write_en_1;
   logic       buf_write_en_2;
   logic       buf_read_en;
   logic       result_valid;
   logic       busy;
   logic       done;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   int req_count = 0;
   int hs_count = 0;
   int done_count = 0;
   int to_count = 0;
   int we2_count = 0;
   int both_count = 0;
   int valid_count = 0;

   eflash_out_seq_ctrl #(
      .OPS_W(4),
      .TIMEOUT_W(8),
      .TIMEOUT_MAX(200)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .start_i(start),
      .mode_cfg_i(mode_cfg),
      .num_ops_i(num_ops),
      .eflash_valid_i(eflash_valid),
      .out_ready_i(out_ready),
      .eflash_req_o(eflash_req),
      .mode_o(mode),
      .buf_write_en_1_o(buf_write_en_1),
      .buf_write_en_2_o(buf_write_en_2),
      .buf_read_en_o(buf_read_en),
      .result_valid_o(result_valid),
      .busy_o(busy),
      .done_o(done),
      .timeout_o(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters sampled mid-cycle while inputs and outputs are stable.
   always @(negedge clk) begin
      if (eflash_req) req_count++;
      if (result_valid && out_ready) hs_count++;
      if (done) done_count++;
      if (timeout) to_count++;
      if (buf_write_en_2) we2_count++;
      if (buf_write_en_1 && buf_write_en_2) both_count++;
      if (result_valid) valid_count++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic s, input logic m, input logic [3:0] n,
                                 input logic v, input logic r);
      start        = s;
      mode_cfg     = m;
      num_ops      = n;
      eflash_valid = v;
      out_ready    = r;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_busy"}, 32'(busy), 0);
      check_output({tag, "_req"}, 32'(eflash_req), 0);
      check_output({tag, "_we"}, 32'({buf_write_en_1, buf_write_en_2}), 0);
      check_output({tag, "_read"}, 32'({buf_read_en, result_valid}), 0);
   endtask

   initial begin
      int n;
      int s_we2, s_done, s_req, s_hs, s_to, s_valid;

      rst = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0);
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      check_idle("reset");
      check_output("reset_mode", 32'(mode), 0);
      check_output("reset_pulses", 32'({done, timeout}), 0);

      $display("[TB] rbr single op");
      s_we2 = we2_count;
      s_done = done_count;
      apply_stimulus(1, 0, 1, 0, 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      check_output("rbr_req", 32'(eflash_req), 1);
      check_output("rbr_busy", 32'(busy), 1);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      check_output("rbr_req_once", 32'(eflash_req), 0);
      check_output("rbr_we1_idle", 32'(buf_write_en_1), 0);
      cyc(); apply_stimulus(0, 0, 1, 1, 0);
      check_output("rbr_we1", 32'(buf_write_en_1), 1);
      check_output("rbr_we2", 32'(buf_write_en_2), 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 1);
      check_output("rbr_read", 32'({buf_read_en, result_valid}), 3);
      check_output("rbr_done_early", 32'(done), 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      check_output("rbr_done", 32'(done), 1);
      check_output("rbr_idle", 32'(busy), 0);
      cyc();
      check_output("rbr_done_pulse", 32'(done), 0);
      check_output("rbr_we2_never", 32'(we2_count - s_we2), 0);
      check_output("rbr_done_count", 32'(done_count - s_done), 1);

      $display("[TB] zero ops treated as one");
      apply_stimulus(1, 0, 0, 0, 0);
      cyc(); apply_stimulus(0, 0, 0, 0, 0);
      cyc(); apply_stimulus(0, 0, 0, 1, 0);
      cyc(); apply_stimulus(0, 0, 0, 0, 1);
      check_output("zero_read", 32'(result_valid), 1);
      cyc(); apply_stimulus(0, 0, 0, 0, 0);
      check_output("zero_done", 32'(done), 1);

      $display("[TB] parallel three ops");
      cyc();
      s_req = req_count;
      s_hs = hs_count;
      s_done = done_count;
      apply_stimulus(1, 1, 3, 0, 0);
      for (int op = 0; op < 3; op++) begin
         cyc(); apply_stimulus(0, 1, 3, 0, 0);
         check_output("par_req1", 32'(eflash_req), 1);
         cyc();
         if (op == 1) apply_stimulus(1, 0, 3, 1, 0);
         else         apply_stimulus(0, 1, 3, 1, 0);
         check_output("par_we", 32'({buf_write_en_1, buf_write_en_2}), 2);
         cyc(); apply_stimulus(0, 1, 3, 0, 0);
         check_output("par_req2", 32'(eflash_req), 1);
         check_output("par_mode", 32'(mode), 1);
         cyc(); apply_stimulus(0, 1, 3, 1, 0);
         check_output("par_we2", 32'({buf_write_en_1, buf_write_en_2}), 1);
         cyc(); apply_stimulus(0, 1, 3, 0, 1);
         check_output("par_read", 32'(result_valid), 1);
         check_output("par_done_early", 32'(done), 0);
      end
      cyc(); apply_stimulus(0, 1, 3, 0, 0);
      check_output("par_done", 32'(done), 1);
      check_output("par_mode_hold", 32'(mode), 1);
      cyc();
      check_output("par_req_count", 32'(req_count - s_req), 6);
      check_output("par_hs_count", 32'(hs_count - s_hs), 3);
      check_output("par_done_count", 32'(done_count - s_done), 1);
      check_output("par_we_exclusive", 32'(both_count), 0);

      $display("[TB] READ backpressure");
      s_valid = valid_count;
      apply_stimulus(1, 0, 1, 0, 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 1);
      cyc(); apply_stimulus(0, 0, 1, 1, 1);
      check_output("bp_no_early_valid", 32'(result_valid), 0);
      cyc();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(0, 0, 1, 0, 0);
         check_output("bp_hold", 32'({buf_read_en, result_valid}), 3);
         cyc();
      end
      apply_stimulus(0, 0, 1, 0, 1);
      check_output("bp_hold_last", 32'(result_valid), 1);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      check_output("bp_done", 32'(done), 1);
      check_output("bp_valid_cycles", 32'(valid_count - s_valid), 6);

      $display("[TB] sense timeout");
      cyc();
      s_done = done_count;
      s_to = to_count;
      apply_stimulus(1, 0, 1, 0, 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      check_output("to_req", 32'(eflash_req), 1);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!timeout && n < 300);
      check_output("to_cycles", 32'(n), 201);
      check_output("to_idle", 32'(busy), 0);
      cyc();
      check_output("to_pulse", 32'(timeout), 0);
      check_output("to_count", 32'(to_count - s_to), 1);
      check_output("to_no_done", 32'(done_count - s_done), 0);

      $display("[TB] valid on last allowed wait cycle");
      s_to = to_count;
      apply_stimulus(1, 0, 1, 0, 0);
      cyc(); apply_stimulus(0, 0, 1, 0, 0);
      repeat (200) cyc();
      apply_stimulus(0, 0, 1, 1, 0);
      check_output("late_we1", 32'(buf_write_en_1), 1);
      cyc(); apply_stimulus(0, 0, 1, 0, 1);
      check_output("late_read", 32'(result_valid), 1);
      check_output("late_no_timeout", 32'(timeout), 0);
      cyc(); apply_stimulus(1, 1, 2, 0, 0);
      check_output("late_done", 32'(done), 1);
      check_output("late_to_count", 32'(to_count - s_to), 0);

      $display("[TB] restart in done cycle then reset in WAIT2");
      cyc(); apply_stimulus(0, 1, 2, 0, 0);
      check_output("restart_req", 32'(eflash_req), 1);
      check_output("restart_mode", 32'(mode), 1);
      s_done = done_count;
      s_to = to_count;
      cyc(); apply_stimulus(0, 1, 2, 1, 0);
      cyc(); apply_stimulus(0, 1, 2, 0, 0);
      check_output("rst_req2", 32'(eflash_req), 1);
      cyc(); apply_stimulus(0, 1, 2, 0, 0);
      check_output("rst_in_wait2", 32'({busy, eflash_req}), 2);
      rst = 1'b1;
      cyc();
      check_idle("rst_mid");
      check_output("rst_mid_mode", 32'(mode), 0);
      rst = 1'b0;
      repeat (3) cyc();
      check_output("rst_no_done", 32'(done_count - s_done), 0);
      check_output("rst_no_timeout", 32'(to_count - s_to), 0);
      check_idle("rst_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
